aes128_iterative_encryptor: RTL and testbench
=============================================

# aes128_iterative_encryptor

Iterative AES-128 encryption core (FIPS-197, encrypt only) and the top-level cipher block of the AES datapath. It captures a 128-bit plaintext and a 128-bit key when enabled. It computes one round per clock with on-the-fly key expansion, then presents the ciphertext with a one-cycle valid pulse.

## Interface
- No parameters; fixed AES-128 (Nk=4, Nr=10).
- AES_clk  in  1  sole clock; all state updates on rising edge.
- AES_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- AES_en  in  1  start request, level-sensitive, sampled on rising edge.
- AES_data_in  in  128  plaintext; bits [127:120] = FIPS-197 byte 0 (in0), column-major.
- AES_key_in  in  128  cipher key; same byte ordering.
- AES_data_out  out  128  ciphertext; same byte ordering; holds last result.
- AES_data_out_valid  out  1  one-cycle pulse when AES_data_out is updated.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with AES_en=1 at an edge:
  - Capture the key into the round-key register.
  - Load state = AES_data_in XOR AES_key_in (initial AddRoundKey).
  - Set round counter = 1 and go to RUN.
- IDLE with AES_en=0: stay in IDLE.
- RUN, each edge:
  - Compute next round key from the current one: RotWord, SubWord, Rcon[r] with Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - Apply SubBytes, ShiftRows, MixColumns (MixColumns skipped when r=10), then AddRoundKey.
  - Increment r.
- After round 10 is registered:
  - Load AES_data_out from the final state.
  - Go to DONE.
- DONE: AES_data_out_valid=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- While AES_en stays high, encryptions repeat back-to-back. Each restart re-samples AES_data_in and AES_key_in in IDLE.
- AES_data_in and AES_key_in are ignored outside the IDLE capture edge. Changing them during RUN or DONE does not affect the result in flight.
- Deasserting AES_en during RUN does not abort; the current encryption completes and pulses valid.
- S-box: standard FIPS-197 forward S-box, implemented combinationally as GF(2^8) inverse plus affine transform. 20 instances: 16 for state bytes, 4 for key schedule.
- MixColumns uses xtime over polynomial 0x11b.

## Timing
- Reset asserted (asynchronously, any time):
  - state = IDLE, round counter = 0.
  - state and key registers = 0.
  - AES_data_out = 0, AES_data_out_valid = 0.
- Reset mid-encryption aborts it; no valid pulse follows.
- Latency, with edge 0 = capture edge:
  - Rounds 1..10 are registered on edges 1..10.
  - Edge 10 also loads AES_data_out, so AES_data_out_valid is high between edge 10 and edge 11.
- Valid pulse is 1 cycle wide. AES_data_out is stable from edge 10 until the next completion or reset.
- With AES_en held high, the IDLE capture falls on edge 12 of the previous run. Throughput is one block per 12 cycles.
- Signals changing within a cycle have no effect; only the rising-edge values matter.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: reset, then AES_en=1 for 1 cycle with key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Required: AES_data_out = 69c4e0d86a7b0430d8cdb78070b4c55a with valid pulse exactly 10 edges after capture; valid low otherwise.
- FIPS-197 Appendix B vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32.
- Input change during RUN:
  - Stimulus: after capturing the C.1 inputs, change AES_data_in every cycle (e.g. a6f2daeb140fa720529e75d521cbc681, then d7b26248e83512275573a1e5e8f263b3).
  - Required: output is still 69c4e0d8…c55a.
- AES_en held high 51 cycles:
  - Stimulus: key aa2bdb40bff6a5e8caa9ba3ebc1e2acc, pt 0000005e000000000000000000000000.
  - Required: valid pulses every 12 cycles, every pulse carries the same ciphertext, and no pulse starts after AES_en falls except the in-flight completion.
- Reset mid-run:
  - Stimulus: assert AES_rst at round 5.
  - Required: AES_data_out=0 and valid=0 immediately (asynchronous); no pulse afterwards until a new AES_en.
- Idle hold:
  - Stimulus: hold AES_en=0 for 100 cycles after completion.
  - Required: AES_data_out holds the last ciphertext and valid stays 0.

Source files
------------

// File: rtl/aes128_iterative_encryptor.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key
// expansion, combinational S-boxes built from GF(2^8) inversion + affine map.
// Byte ordering: bits [127:120] are byte 0, bytes are column-major.
//
// Handshake: AES_en is a level request sampled only in IDLE. Once captured,
// the block runs to completion: AES_data_out_valid pulses for exactly one
// cycle when AES_data_out is updated. There is no backpressure. AES_data_out
// then holds its value until the next completion or reset.
module aes128_iterative_encryptor (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic [1:0]   dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] key_q, key_d;
  logic [127:0] state_q, state_d;
  logic [127:0] dout_q, dout_d;
  logic         valid_q, valid_d;

  logic [127:0] next_key;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = x;
    res = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] a;
    a = gf_inv(x);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Next round key: RotWord, SubWord (4 S-boxes) and Rcon on the last word.
  always_comb begin
    logic [31:0] w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;
    w3   = key_q[31:0];
    temp = {sbox(w3[23:16]) ^ rcon(round_q), sbox(w3[15:8]),
            sbox(w3[7:0]), sbox(w3[31:24])};
    n0   = key_q[127:96] ^ temp;
    n1   = key_q[95:64] ^ n0;
    n2   = key_q[63:32] ^ n1;
    n3   = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // One cipher round: SubBytes (16 S-boxes), ShiftRows, MixColumns
  // (bypassed in round 10), AddRoundKey with the freshly expanded key.
  always_comb begin
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [127:0] sr_vec;
    logic [127:0] mc_vec;
    for (int i = 0; i < 16; i++) sb[i] = sbox(state_q[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      sr_vec[127-32*c -: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
      mc_vec[127-32*c -: 32] = mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
    end
    round_out = ((round_q == 4'd10) ? sr_vec : mc_vec) ^ next_key;
  end

  // Control: capture in IDLE, ten rounds in RUN, one-cycle DONE for the pulse.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    key_d   = key_q;
    state_d = state_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (AES_en) begin
          key_d   = AES_key_in;
          state_d = AES_data_in ^ AES_key_in;
          round_d = 4'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        key_d   = next_key;
        state_d = round_out;
        round_d = round_q + 4'd1;
        if (round_q == 4'd10) begin
          dout_d  = round_out;
          valid_d = 1'b1;
          fsm_d   = ST_DONE;
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // State registers, cleared asynchronously so a reset aborts any run.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      key_q   <= 128'd0;
      state_q <= 128'd0;
      dout_q  <= 128'd0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      key_q   <= key_d;
      state_q <= state_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign AES_data_out       = dout_q;
  assign AES_data_out_valid = valid_q;
  assign dbg_state_o        = fsm_q;

endmodule

// File: tb/tb_aes128_iterative_encryptor.sv
// Bench for aes128_iterative_encryptor: directed FIPS-197 vectors, input
// changes during a run, back-to-back runs, mid-run reset and idle hold.
module tb_aes128_iterative_encryptor;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_H  = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
  localparam logic [127:0] PT_H   = 128'h0000005e000000000000000000000000;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk;
  logic         rst;
  logic         en;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;
  logic         data_out_valid;
  logic [1:0]   dbg_state;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];

  aes128_iterative_encryptor dut (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .AES_en             (en),
    .AES_data_in        (data_in),
    .AES_key_in         (key_in),
    .AES_data_out       (data_out),
    .AES_data_out_valid (data_out_valid),
    .dbg_state_o        (dbg_state)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-table reference cipher used for the vector without a published answer.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? (({a[6:0], 1'b0}) ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] rc;
    logic [7:0] t0, t1, t2, t3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      t0 = SBOX[k[13]] ^ rc; t1 = SBOX[k[14]]; t2 = SBOX[k[15]]; t3 = SBOX[k[12]];
      k[0] = k[0] ^ t0; k[1] = k[1] ^ t1; k[2] = k[2] ^ t2; k[3] = k[3] ^ t3;
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = SBOX[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = xt(t[4*c]) ^ (xt(t[4*c+1]) ^ t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ (xt(t[4*c+2]) ^ t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ (xt(t[4*c+3]) ^ t[4*c+3]);
          s[4*c+3] = (xt(t[4*c]) ^ t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid pulse pops one expected ciphertext and edge.
  always @(negedge clk) begin
    if (!rst && data_out_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pulse: got data %h at edge %0d expected no pulse", data_out, cyc);
      end else begin
        check("ciphertext", data_out, exp_q.pop_front());
        check_int("pulse_edge", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // Driver: one-cycle request; capture falls on the next rising edge.
  task automatic start_one(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct);
    @(negedge clk);
    key_in  = key;
    data_in = pt;
    en      = 1'b1;
    exp_q.push_back(ct);
    exp_cyc_q.push_back(cyc + 11);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] ct_h;
    int           start_cyc;
    rst     = 1'b1;
    en      = 1'b0;
    data_in = 128'd0;
    key_in  = 128'd0;
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 128'd0);
    check("reset_valid", {127'd0, data_out_valid}, 128'd0);
    check("reset_state", {126'd0, dbg_state}, 128'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // FIPS-197 C.1 and Appendix B
    start_one(KEY_C1, PT_C1, CT_C1);
    wait_drain(40);
    start_one(KEY_B, PT_B, CT_B);
    wait_drain(40);

    // Inputs changing every cycle during the run must not disturb it
    start_one(KEY_C1, PT_C1, CT_C1);
    for (int i = 0; i < 12; i++) begin
      data_in = (i == 0) ? 128'ha6f2daeb140fa720529e75d521cbc681 :
                (i == 1) ? 128'hd7b26248e83512275573a1e5e8f263b3 :
                {$urandom, $urandom, $urandom, $urandom};
      key_in  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    wait_drain(40);

    // AES_en held 51 cycles: captures every 12 edges while en is high
    ct_h = aes_ref(KEY_H, PT_H);
    @(negedge clk);
    key_in    = KEY_H;
    data_in   = PT_H;
    en        = 1'b1;
    start_cyc = cyc + 1;
    for (int k = 0; 12 * k < 51; k++) begin
      exp_q.push_back(ct_h);
      exp_cyc_q.push_back(start_cyc + 12 * k + 10);
    end
    repeat (51) @(negedge clk);
    en = 1'b0;
    wait_drain(40);
    repeat (15) @(negedge clk);

    // Reset at round 5 aborts the run with no later pulse
    @(negedge clk);
    key_in  = KEY_B;
    data_in = PT_B;
    en      = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_data_out", data_out, 128'd0);
    check("async_reset_valid", {127'd0, data_out_valid}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_reset_data_out", data_out, 128'd0);

    // Idle hold: result stays put with no pulses
    start_one(KEY_B, PT_B, CT_B);
    wait_drain(40);
    repeat (50) @(negedge clk);
    check("idle_hold_50", data_out, CT_B);
    repeat (50) @(negedge clk);
    check("idle_hold_100", data_out, CT_B);
    check_int("leftover_expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
